layered_pixel_gen: RTL and testbench

- Next-generation pixel generator: composites N_SPRITES sprite layers, one map layer and a background colour into a registered RGB stream.
- Position and size are parameterised. Sprite pixels matching a colour key are transparent.
- Sprite positions are double-buffered at frame start, so there is no mid-frame tearing.
- Sits between the VGA controller and the VGA port. Sprite/map ROMs are external synchronous-read memories addressed by this block.

---
 rtl/pixgen_pkg.sv | 27 ++
 rtl/sprite_hit_unit.sv | 79 +++++++
 rtl/layered_pixel_gen.sv | 123 ++++++++++++
 tb/tb_layered_pixel_gen.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixgen_pkg.sv
// Shared colours, pipeline latency and the rectangle-hit rule for layered_pixel_gen.
package pixgen_pkg;

  localparam logic [11:0] BLACK   = 12'h000;
  localparam logic [11:0] WHITE   = 12'hFFF;
  localparam logic [11:0] RED     = 12'hF00;
  localparam logic [11:0] GREEN   = 12'h0F0;
  localparam logic [11:0] BLUE    = 12'h00F;
  localparam logic [11:0] MAGENTA = 12'hF0F;

  localparam logic [11:0] TRANSPARENT_KEY = MAGENTA;
  localparam logic [11:0] BG_COLOR        = WHITE;

  localparam int PIXGEN_LATENCY = 3;
  localparam int COORD_W        = 16;

  // lo+size is formed one bit wider than the coordinates, so a span at the
  // far edge of the screen never wraps back to coordinate 0.
  function automatic logic in_span(input logic [COORD_W-1:0] p,
                                   input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W-1:0] size);
    logic [COORD_W:0] hi;
    hi = {1'b0, lo} + {1'b0, size};
    return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < hi);
  endfunction

endpackage

// File: rtl/sprite_hit_unit.sv
// One sprite layer: frame-start shadow of position/enable, stage-1 hit + ROM address,
// stage-2 hit delay. PIXGEN_FLIP_EN adds a shadowed horizontal-mirror control.
module sprite_hit_unit
  import pixgen_pkg::*;
#(
  parameter int SCREEN_WIDTH = 10,
  parameter int CHAR_WIDTH_X = 32,
  parameter int CHAR_WIDTH_Y = 32,
  parameter int SPR_ADDR_W   = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    frame_start_i,
  input  logic [SCREEN_WIDTH-1:0] x_i,
  input  logic [SCREEN_WIDTH-1:0] y_i,
  input  logic [SCREEN_WIDTH-1:0] spr_x_i,
  input  logic [SCREEN_WIDTH-1:0] spr_y_i,
  input  logic                    spr_en_i,
`ifdef PIXGEN_FLIP_EN
  input  logic                    spr_flip_i,
`endif
  output logic [SPR_ADDR_W-1:0]   addr_o,
  output logic                    hit2_o
);

  logic [SCREEN_WIDTH-1:0] sx_q, sy_q;
  logic                    en_q;
  logic                    hit1_d, hit1_q, hit2_q;
  logic [SPR_ADDR_W-1:0]   addr_d, addr_q;
  logic [SCREEN_WIDTH-1:0] dx, dy;
  logic [SPR_ADDR_W-1:0]   row, col;
`ifdef PIXGEN_FLIP_EN
  logic                    flip_q;
`endif

  always_comb begin
    dx  = x_i - sx_q;
    dy  = y_i - sy_q;
    row = SPR_ADDR_W'(dy);
    col = SPR_ADDR_W'(dx);
`ifdef PIXGEN_FLIP_EN
    if (flip_q) col = SPR_ADDR_W'(CHAR_WIDTH_X - 1) - col;
`endif
    hit1_d = en_q
          && in_span(COORD_W'(x_i), COORD_W'(sx_q), COORD_W'(CHAR_WIDTH_X))
          && in_span(COORD_W'(y_i), COORD_W'(sy_q), COORD_W'(CHAR_WIDTH_Y));
    addr_d = hit1_d ? (row * SPR_ADDR_W'(CHAR_WIDTH_X) + col) : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sx_q   <= '0;
      sy_q   <= '0;
      en_q   <= 1'b0;
`ifdef PIXGEN_FLIP_EN
      flip_q <= 1'b0;
`endif
      hit1_q <= 1'b0;
      hit2_q <= 1'b0;
      addr_q <= '0;
    end else begin
      if (frame_start_i) begin
        sx_q   <= spr_x_i;
        sy_q   <= spr_y_i;
        en_q   <= spr_en_i;
`ifdef PIXGEN_FLIP_EN
        flip_q <= spr_flip_i;
`endif
      end
      hit1_q <= hit1_d;
      addr_q <= addr_d;
      hit2_q <= hit1_q;
    end
  end

  assign addr_o = addr_q;
  assign hit2_o = hit2_q;

endmodule

// File: rtl/layered_pixel_gen.sv
// Composites N_SPRITES sprite layers, a fixed map window and a background colour
// into a 3-cycle-latency RGB stream. Optional PIXGEN_FLIP_EN adds per-sprite mirroring.
module layered_pixel_gen
  import pixgen_pkg::*;
#(
  parameter int N_SPRITES    = 4,
  parameter int PIXEL_WIDTH  = 12,
  parameter int SCREEN_WIDTH = 10,
  parameter int CHAR_WIDTH_X = 32,
  parameter int CHAR_WIDTH_Y = 32,
  parameter int SPR_ADDR_W   = 10,
  parameter int MAP_X_OFFSET = 270,
  parameter int MAP_Y_OFFSET = 50,
  parameter int MAP_WIDTH_X  = 100,
  parameter int MAP_WIDTH_Y  = 100,
  parameter int MAP_ADDR_W   = 14,
  parameter logic [PIXEL_WIDTH-1:0] TRANSPARENT_KEY = PIXEL_WIDTH'(pixgen_pkg::TRANSPARENT_KEY),
  parameter logic [PIXEL_WIDTH-1:0] BG_COLOR        = PIXEL_WIDTH'(pixgen_pkg::BG_COLOR)
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst,
  input  logic                              video_on,
  input  logic                              hsync_in,
  input  logic                              vsync_in,
  input  logic                              frame_start,
  input  logic [SCREEN_WIDTH-1:0]           x,
  input  logic [SCREEN_WIDTH-1:0]           y,
  input  logic [N_SPRITES*SCREEN_WIDTH-1:0] spr_x,
  input  logic [N_SPRITES*SCREEN_WIDTH-1:0] spr_y,
  input  logic [N_SPRITES-1:0]              spr_en,
`ifdef PIXGEN_FLIP_EN
  input  logic [N_SPRITES-1:0]              spr_flip,
`endif
  output logic [N_SPRITES*SPR_ADDR_W-1:0]   spr_addr,
  input  logic [N_SPRITES*PIXEL_WIDTH-1:0]  spr_data,
  output logic [MAP_ADDR_W-1:0]             map_addr,
  input  logic [PIXEL_WIDTH-1:0]            map_data,
  output logic [PIXEL_WIDTH-1:0]            rgb,
  output logic                              hsync_out,
  output logic                              vsync_out,
  output logic                              video_on_out
);

  localparam int LAT = PIXGEN_LATENCY;

  logic [N_SPRITES-1:0]    hit2;
  logic                    map_hit1_d, map_hit1_q, map_hit2_q;
  logic [MAP_ADDR_W-1:0]   map_addr_d, map_addr_q;
  logic [SCREEN_WIDTH-1:0] mdx, mdy;
  logic [LAT-1:0]          von_pipe_q, hs_pipe_q, vs_pipe_q;
  logic [PIXEL_WIDTH-1:0]  rgb_d, rgb_q;

  for (genvar g = 0; g < N_SPRITES; g++) begin : g_spr
    sprite_hit_unit #(
      .SCREEN_WIDTH(SCREEN_WIDTH),
      .CHAR_WIDTH_X(CHAR_WIDTH_X),
      .CHAR_WIDTH_Y(CHAR_WIDTH_Y),
      .SPR_ADDR_W  (SPR_ADDR_W)
    ) u_hit (
      .clk_i        (sys_clk),
      .rst_i        (sys_rst),
      .frame_start_i(frame_start),
      .x_i          (x),
      .y_i          (y),
      .spr_x_i      (spr_x[g*SCREEN_WIDTH +: SCREEN_WIDTH]),
      .spr_y_i      (spr_y[g*SCREEN_WIDTH +: SCREEN_WIDTH]),
      .spr_en_i     (spr_en[g]),
`ifdef PIXGEN_FLIP_EN
      .spr_flip_i   (spr_flip[g]),
`endif
      .addr_o       (spr_addr[g*SPR_ADDR_W +: SPR_ADDR_W]),
      .hit2_o       (hit2[g])
    );
  end

  always_comb begin
    mdx        = x - SCREEN_WIDTH'(MAP_X_OFFSET);
    mdy        = y - SCREEN_WIDTH'(MAP_Y_OFFSET);
    map_hit1_d = in_span(COORD_W'(x), COORD_W'(MAP_X_OFFSET), COORD_W'(MAP_WIDTH_X))
              && in_span(COORD_W'(y), COORD_W'(MAP_Y_OFFSET), COORD_W'(MAP_WIDTH_Y));
    map_addr_d = map_hit1_d
               ? MAP_ADDR_W'(mdy) * MAP_ADDR_W'(MAP_WIDTH_X) + MAP_ADDR_W'(mdx)
               : '0;
  end

  // Walk sprites from lowest priority up so the lowest opaque index wins.
  always_comb begin
    rgb_d = BG_COLOR;
    if (map_hit2_q) rgb_d = map_data;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (hit2[i] && spr_data[i*PIXEL_WIDTH +: PIXEL_WIDTH] != TRANSPARENT_KEY)
        rgb_d = spr_data[i*PIXEL_WIDTH +: PIXEL_WIDTH];
    end
    if (!von_pipe_q[LAT-2]) rgb_d = '0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      map_hit1_q <= 1'b0;
      map_hit2_q <= 1'b0;
      map_addr_q <= '0;
      von_pipe_q <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      rgb_q      <= '0;
    end else begin
      map_hit1_q <= map_hit1_d;
      map_addr_q <= map_addr_d;
      map_hit2_q <= map_hit1_q;
      von_pipe_q <= {von_pipe_q[LAT-2:0], video_on};
      hs_pipe_q  <= {hs_pipe_q[LAT-2:0], hsync_in};
      vs_pipe_q  <= {vs_pipe_q[LAT-2:0], vsync_in};
      rgb_q      <= rgb_d;
    end
  end

  assign map_addr     = map_addr_q;
  assign rgb          = rgb_q;
  assign video_on_out = von_pipe_q[LAT-1];
  assign hsync_out    = hs_pipe_q[LAT-1];
  assign vsync_out    = vs_pipe_q[LAT-1];

endmodule

// File: tb/tb_layered_pixel_gen.sv
// Directed and randomised checks of layered_pixel_gen against a per-pixel reference
// model with behavioural sprite/map ROMs; builds with or without PIXGEN_FLIP_EN.
module tb_layered_pixel_gen;

  localparam int NS  = 4;
  localparam int PW  = 12;
  localparam int SW  = 10;
  localparam int CW  = 32;
  localparam int CH  = 32;
  localparam int AW  = 10;
  localparam int MAW = 14;
  localparam int MXO = 270;
  localparam int MYO = 50;
  localparam int MW  = 100;
  localparam int MH  = 100;
  localparam logic [PW-1:0] KEY = 12'hF0F;
  localparam logic [PW-1:0] BG  = 12'hFFF;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             video_on, hsync_in, vsync_in, frame_start;
  logic [SW-1:0]    x, y;
  logic [NS*SW-1:0] spr_x, spr_y;
  logic [NS-1:0]    spr_en;
`ifdef PIXGEN_FLIP_EN
  logic [NS-1:0]    spr_flip;
`endif
  logic [NS*AW-1:0] spr_addr;
  logic [NS*PW-1:0] spr_data;
  logic [MAW-1:0]   map_addr;
  logic [PW-1:0]    map_data;
  logic [PW-1:0]    rgb;
  logic             hsync_out, vsync_out, video_on_out;

  layered_pixel_gen dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .video_on    (video_on),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .frame_start (frame_start),
    .x           (x),
    .y           (y),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_en      (spr_en),
`ifdef PIXGEN_FLIP_EN
    .spr_flip    (spr_flip),
`endif
    .spr_addr    (spr_addr),
    .spr_data    (spr_data),
    .map_addr    (map_addr),
    .map_data    (map_data),
    .rgb         (rgb),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .video_on_out(video_on_out)
  );

  always #5 sys_clk = ~sys_clk;

  logic [PW-1:0] spr_rom [NS][1024];
  logic [PW-1:0] map_rom [16384];

  // Synchronous-read ROMs: data follows the address by one clock.
  always @(posedge sys_clk) begin
    for (int i = 0; i < NS; i++) spr_data[i*PW +: PW] <= spr_rom[i][spr_addr[i*AW +: AW]];
    map_data <= map_rom[map_addr];
  end

  int in_x[NS], in_y[NS];
  bit in_en[NS], in_flip[NS];
  int sh_x[NS], sh_y[NS];
  bit sh_en[NS], sh_flip[NS];

  typedef struct { logic [PW-1:0] rgb; logic von, hs, vs; } exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic bit in_rect(int px, int py, int rx, int ry, int w, int h);
    return px >= rx && px < rx + w && py >= ry && py < ry + h;
  endfunction

  function automatic bit spr_hit(int i, int px, int py);
    return sh_en[i] && in_rect(px, py, sh_x[i], sh_y[i], CW, CH);
  endfunction

  function automatic int spr_off(int i, int px, int py);
    int col = px - sh_x[i];
    if (sh_flip[i]) col = CW - 1 - col;
    return ((py - sh_y[i]) * CW + col) % 1024;
  endfunction

  function automatic logic [PW-1:0] model_rgb(int px, int py, bit vo);
    if (!vo) return '0;
    for (int i = 0; i < NS; i++)
      if (spr_hit(i, px, py) && spr_rom[i][spr_off(i, px, py)] != KEY)
        return spr_rom[i][spr_off(i, px, py)];
    if (in_rect(px, py, MXO, MYO, MW, MH)) return map_rom[(py - MYO) * MW + (px - MXO)];
    return BG;
  endfunction

  // Presents one pixel, advances one clock, checks ROM addresses of this pixel
  // and the rgb/sync of the pixel presented two clocks earlier.
  task automatic cycle(input int px, input int py, input bit vo, input bit hs,
                       input bit vs, input bit fs);
    exp_t e;
    int   ea[NS];
    int   em;
    x = SW'(px); y = SW'(py);
    video_on = vo; hsync_in = hs; vsync_in = vs; frame_start = fs;
    for (int i = 0; i < NS; i++) begin
      spr_x[i*SW +: SW] = SW'(in_x[i]);
      spr_y[i*SW +: SW] = SW'(in_y[i]);
      spr_en[i] = in_en[i];
`ifdef PIXGEN_FLIP_EN
      spr_flip[i] = in_flip[i];
`endif
    end
    e.rgb = model_rgb(px, py, vo); e.von = vo; e.hs = hs; e.vs = vs;
    exp_q.push_back(e);
    for (int i = 0; i < NS; i++) ea[i] = spr_hit(i, px, py) ? spr_off(i, px, py) : 0;
    em = in_rect(px, py, MXO, MYO, MW, MH) ? (py - MYO) * MW + (px - MXO) : 0;
    @(posedge sys_clk); #1;
    if (fs)
      for (int i = 0; i < NS; i++) begin
        sh_x[i] = in_x[i]; sh_y[i] = in_y[i]; sh_en[i] = in_en[i]; sh_flip[i] = in_flip[i];
      end
    for (int i = 0; i < NS; i++)
      chk($sformatf("spr_addr%0d", i), 32'(spr_addr[i*AW +: AW]), 32'(ea[i]));
    chk("map_addr", 32'(map_addr), 32'(em));
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      chk("rgb", 32'(rgb), 32'(e.rgb));
      chk("video_on_out", 32'(video_on_out), 32'(e.von));
      chk("hsync_out", 32'(hsync_out), 32'(e.hs));
      chk("vsync_out", 32'(vsync_out), 32'(e.vs));
    end
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    x = 10'd100; y = 10'd50; video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    frame_start = 1'b0;
    @(posedge sys_clk); #1;
    chk("rst_rgb", 32'(rgb), 32'h0);
    chk("rst_von", 32'(video_on_out), 32'h0);
    chk("rst_hs", 32'(hsync_out), 32'h0);
    chk("rst_vs", 32'(vsync_out), 32'h0);
    chk("rst_spr_addr", 32'(spr_addr), 32'h0);
    chk("rst_map_addr", 32'(map_addr), 32'h0);
    sys_rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < NS; i++) begin
      sh_x[i] = 0; sh_y[i] = 0; sh_en[i] = 1'b0; sh_flip[i] = 1'b0;
    end
  endtask

  initial begin
    int exp_flip;
    sys_rst = 1'b1; video_on = 0; hsync_in = 0; vsync_in = 0; frame_start = 0;
    x = '0; y = '0; spr_x = '0; spr_y = '0; spr_en = '0;
`ifdef PIXGEN_FLIP_EN
    spr_flip = '0;
`endif
    for (int i = 0; i < NS; i++) begin
      in_x[i] = 0; in_y[i] = 0; in_en[i] = 0; in_flip[i] = 0;
      for (int a = 0; a < 1024; a++)
        spr_rom[i][a] = ($urandom_range(0, 3) == 0) ? KEY : 12'($urandom);
    end
    for (int a = 0; a < 16384; a++) map_rom[a] = 12'($urandom);
    spr_rom[0][0] = 12'h2A6;
    spr_rom[0][1] = KEY;    spr_rom[1][1] = 12'h00F;
    spr_rom[0][2] = 12'hA21;
    spr_rom[0][3] = KEY;    spr_rom[1][3] = KEY;

    do_reset();

    // Single sprite, first pixel of the sprite
    in_x[0] = 100; in_y[0] = 50; in_en[0] = 1;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(100, 50, 1, 0, 0, 0);
    chk("t1_addr", 32'(spr_addr[0 +: AW]), 32'h0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t1_rgb", 32'(rgb), 32'h2A6);

    // Overlap: transparent top sprite shows sprite 1; opaque top wins; both clear -> BG
    in_x[0] = 200; in_y[0] = 200; in_x[1] = 200; in_y[1] = 200; in_en[1] = 1;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(201, 200, 1, 0, 0, 0);
    cycle(202, 200, 1, 0, 0, 0);
    cycle(203, 200, 1, 0, 0, 0);
    chk("t2_under", 32'(rgb), 32'h00F);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t2_top", 32'(rgb), 32'hA21);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t2_clear", 32'(rgb), 32'(BG));

    // Sprites at the right and bottom edges must not wrap to column/row 0
    in_x[0] = 1020; in_y[0] = 100; in_x[1] = 300; in_y[1] = 1020;
    cycle(0, 0, 0, 0, 0, 1);
    cycle(5, 100, 1, 0, 0, 0);
    chk("t3_addr", 32'(spr_addr[0 +: AW]), 32'h0);
    cycle(300, 3, 1, 0, 0, 0);
    cycle(1022, 100, 1, 0, 0, 0);
    chk("t3_nowrap_x", 32'(rgb), 32'(BG));
    cycle(0, 0, 0, 0, 0, 0);
    chk("t3_nowrap_y", 32'(rgb), 32'(BG));
    cycle(0, 0, 0, 0, 0, 0);
    chk("t3_edge", 32'(rgb), 32'hA21);

    // Mid-frame position change is ignored until frame_start
    in_x[0] = 100; in_y[0] = 100; in_en[1] = 0;
    cycle(100, 100, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t4_hold", 32'(rgb), 32'(BG));
    cycle(0, 0, 0, 0, 0, 1);
    cycle(100, 100, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t4_move", 32'(rgb), 32'h2A6);

    // Blanking over a sprite hit, sync delay lines
    cycle(100, 100, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t5_blank", 32'(rgb), 32'h0);
    chk("t5_hs", 32'(hsync_out), 32'h1);
    cycle(0, 0, 0, 0, 0, 0);
    chk("t5_vs", 32'(vsync_out), 32'h1);
    chk("t5_hs_low", 32'(hsync_out), 32'h0);

    // Horizontal flip of sprite 0 at (100,50)
    in_x[0] = 100; in_y[0] = 50;
`ifdef PIXGEN_FLIP_EN
    in_flip[0] = 1; exp_flip = 31;
`else
    exp_flip = 0;
`endif
    cycle(0, 0, 0, 0, 0, 1);
    cycle(100, 50, 1, 0, 0, 0);
    chk("flip_addr", 32'(spr_addr[0 +: AW]), 32'(exp_flip));
    in_flip[0] = 0;
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // Mid-stream reset hides every sprite until the next frame_start
    do_reset();

    for (int n = 0; n < 3000; n++) begin
      int px, py;
      bit fs;
      if ($urandom_range(0, 24) == 0)
        for (int i = 0; i < NS; i++) begin
          in_x[i]  = ($urandom_range(0, 7) == 0) ? $urandom_range(990, 1023) : $urandom_range(240, 360);
          in_y[i]  = ($urandom_range(0, 7) == 0) ? $urandom_range(990, 1023) : $urandom_range(30, 150);
          in_en[i] = ($urandom_range(0, 3) != 0);
`ifdef PIXGEN_FLIP_EN
          in_flip[i] = $urandom_range(0, 1) != 0;
`endif
        end
      fs = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 15) == 0) begin
        px = $urandom_range(0, 1023); py = $urandom_range(0, 1023);
      end else begin
        px = $urandom_range(230, 400); py = $urandom_range(20, 190);
      end
      cycle(px, py, $urandom_range(0, 7) != 0, $urandom_range(0, 1) != 0,
            $urandom_range(0, 1) != 0, fs);
    end
    for (int n = 0; n < 3; n++) cycle(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
